// File: rtl/itr_ctrl.sv
// Vectored interrupt controller: edge-triggered pending bits, fixed priority,
// nested preemption with a bounded in-service stack.
module itr_ctrl #(
    parameter int unsigned NUITRS = 4,
    parameter int unsigned MINSTW = 9,
    parameter int unsigned ITRBAS = 1,
    parameter int unsigned ITRSTP = 4,
    parameter int unsigned NDEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUITRS-1:0]             irq_in,
    input  logic                          itr_en,
    input  logic                          mask_wr,
    input  logic [NUITRS-1:0]             mask_in,
    input  logic                          ack,
    input  logic                          reti,
    output logic                          itr,
    output logic [MINSTW-1:0]             itr_addr,
    output logic [$clog2(NUITRS)-1:0]     itr_id,
    output logic [NUITRS-1:0]             pending,
    output logic [$clog2(NDEPTH+1)-1:0]   nest_lvl
);

    localparam int unsigned IDW = $clog2(NUITRS);
    localparam int unsigned NLW = $clog2(NDEPTH + 1);

    typedef enum logic {IDLE, REQ} state_e;

    state_e              state_q, state_d;
    logic                itr_q, itr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [MINSTW-1:0]   addr_q, addr_d;
    logic [NUITRS-1:0]   pend_q, pend_d;
    logic [NUITRS-1:0]   mask_q, mask_d;
    logic [NUITRS-1:0]   irq_q, irq_d;
    logic [NUITRS-1:0]   irq_dly_q, irq_dly_d;
    logic                arm_q, arm_d;
    logic [NLW-1:0]      nest_q, nest_d;
    logic [IDW-1:0]      stk_q [NDEPTH];
    logic [IDW-1:0]      stk_d [NDEPTH];

    logic [NUITRS-1:0]   rise;
    logic [NUITRS-1:0]   clr;
    logic                found;
    logic [IDW-1:0]      cand_id;
    logic [IDW-1:0]      top_id;
    logic                eligible;
    logic                push;
    logic                pop;
    logic [NLW-1:0]      wr_idx;

    always_comb begin
        state_d   = state_q;
        itr_d     = itr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        mask_d    = mask_wr ? mask_in : mask_q;
        irq_d     = irq_in;
        // First post-reset sample primes both stages so a held line is not seen as an edge
        irq_dly_d = arm_q ? irq_q : irq_in;
        arm_d     = 1'b1;
        clr       = '0;
        push      = 1'b0;
        pop       = reti && (nest_q != '0);
        stk_d     = stk_q;
        rise      = irq_q & ~irq_dly_q;

        found   = 1'b0;
        cand_id = '0;
        for (int i = int'(NUITRS) - 1; i >= 0; i--) begin
            if (pend_q[i] && mask_q[i]) begin
                found   = 1'b1;
                cand_id = IDW'(i);
            end
        end

        top_id = '0;
        for (int i = 0; i < int'(NDEPTH); i++) begin
            if (NLW'(i + 1) == nest_q) top_id = stk_q[i];
        end

        eligible = found && ((nest_q == '0) || (cand_id < top_id))
                   && (nest_q < NLW'(NDEPTH));

        case (state_q)
            IDLE: begin
                if (itr_en && eligible) begin
                    state_d = REQ;
                    itr_d   = 1'b1;
                    id_d    = cand_id;
                    addr_d  = MINSTW'(ITRBAS + ITRSTP * 32'(cand_id));
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = IDLE;
                    itr_d   = 1'b0;
                    clr     = NUITRS'(1) << id_q;
                    push    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge in the ack cycle wins over the clear
        pend_d = (pend_q & ~clr) | rise;

        // Simultaneous push and pop replaces the top entry in place
        wr_idx = pop ? (nest_q - NLW'(1)) : nest_q;
        for (int i = 0; i < int'(NDEPTH); i++) begin
            if (push && (NLW'(i) == wr_idx)) stk_d[i] = id_q;
        end
        nest_d = nest_q + NLW'(push) - NLW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            itr_q     <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '1;
            irq_q     <= '0;
            irq_dly_q <= '0;
            arm_q     <= 1'b0;
            nest_q    <= '0;
            for (int i = 0; i < int'(NDEPTH); i++) stk_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            itr_q     <= itr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            irq_dly_q <= irq_dly_d;
            arm_q     <= arm_d;
            nest_q    <= nest_d;
            stk_q     <= stk_d;
        end
    end

    assign itr      = itr_q;
    assign itr_id   = id_q;
    assign itr_addr = addr_q;
    assign pending  = pend_q;
    assign nest_lvl = nest_q;

endmodule
